// File: rtl/hps_gp_reg_bridge_pkg.sv
// Shared definitions for the HPS general-purpose register bridge.
//  - state_t     : bridge FSM states
//  - ADDR_*      : register file addresses
//  - CMD_*/RSP_* : bit positions inside the gp_out command word and the gp_in
//                  response word
//  - pack_rsp    : assembles a response word from its fields
package hps_gp_bridge_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SETTLE,
        EXEC
    } state_t;

    localparam logic [3:0] ADDR_ID      = 4'd0;
    localparam logic [3:0] ADDR_SCRATCH = 4'd1;
    localparam logic [3:0] ADDR_LED     = 4'd2;
    localparam logic [3:0] ADDR_STATUS  = 4'd3;
    localparam logic [3:0] ADDR_TXN     = 4'd4;

    localparam int CMD_REQ_BIT  = 31;
    localparam int CMD_WR_BIT   = 30;
    localparam int CMD_ADDR_LSB = 26;
    localparam int CMD_DATA_LSB = 0;

    localparam int RSP_ACK_BIT  = 31;

    function automatic logic [31:0] pack_rsp(input logic        ack,
                                             input logic        err,
                                             input logic [3:0]  addr,
                                             input logic [15:0] rdata);
        return {ack, err, addr, 10'h000, rdata};
    endfunction

endpackage

// File: rtl/hps_gp_reg_bridge_if.sv
// Bus between the HPS general-purpose lines and the register bridge.
//  gp_out : 32-bit command word from hps_0_h2f_gp_gp_out (HPS -> fabric)
//  gp_in  : 32-bit response word to hps_0_h2f_gp_gp_in (fabric -> HPS)
// The master modport is the HPS side, the slave modport is the bridge.
interface hps_gp_reg_bridge_if;

    logic [31:0] gp_out;
    logic [31:0] gp_in;

    modport master (output gp_out, input gp_in);
    modport slave  (input gp_out, output gp_in);

endinterface

// File: rtl/hps_gp_reg_bridge_sync.sv
// gp_sync2: plain two-flop vector synchroniser.
//  clk : destination clock
//  rst : asynchronous, active-high reset (clears both stages)
//  d   : asynchronous input vector
//  q   : synchronised output vector
// Bits are synchronised independently; callers must tolerate inter-bit skew.
module gp_sync2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hps_gp_reg_bridge.sv
// hps_gp_reg_bridge: toggle-handshake register bridge on the HPS GP lines.
//  clk_clk     : fabric clock
//  reset_reset : asynchronous, active-high reset
//  gp          : slave side of the GP bus (gp_out command in, gp_in response out)
//  sw_i        : slide switches (already synchronised)
//  pb_i        : push buttons (already synchronised)
//  led_o       : registered LED drive
// Linux flips gp_out[31] to issue a command; the bridge answers by flipping
// gp_in[31] once the access is done. Registers: ID, SCRATCH, LED, STATUS, TXN_CNT.
module hps_gp_reg_bridge
    import hps_gp_bridge_pkg::*;
#(
    parameter logic [15:0] ID_VALUE      = 16'hA5C1,
    parameter int          SETTLE_CYCLES = 2,
    parameter int          LED_W         = 8,
    parameter int          SW_W          = 4,
    parameter int          PB_W          = 2
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    hps_gp_reg_bridge_if.slave   gp,
    input  logic [SW_W-1:0]      sw_i,
    input  logic [PB_W-1:0]      pb_i,
    output logic [LED_W-1:0]     led_o
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [31:0]      sync_q;
    state_t           state;
    logic [1:0]       init_cnt;
    logic [CNT_W-1:0] cnt;
    logic             last_req;
    logic [31:0]      gp_in_q;
    logic [15:0]      scratch_q;
    logic [LED_W-1:0] led_q;
    logic [15:0]      txn_q;

    logic             cmd_wr;
    logic [3:0]       cmd_addr;
    logic [15:0]      cmd_wdata;
    logic [15:0]      led_rd;
    logic [15:0]      status_val;
    logic [15:0]      rd_val;
    logic             mapped;
    logic             writable;
    logic             rsp_err;
    logic             do_write;
    logic [15:0]      rsp_rdata;
    logic             unused_bits;

    gp_sync2 #(.WIDTH(32)) u_sync (
        .clk (clk_clk),
        .rst (reset_reset),
        .d   (gp.gp_out),
        .q   (sync_q)
    );

    assign cmd_wr      = sync_q[CMD_WR_BIT];
    assign cmd_addr    = sync_q[CMD_ADDR_LSB +: 4];
    assign cmd_wdata   = sync_q[CMD_DATA_LSB +: 16];
    assign unused_bits = ^sync_q[25:16];

    assign led_rd     = {{(16 - LED_W){1'b0}}, led_q};
    assign status_val = {{(16 - PB_W - SW_W){1'b0}}, pb_i, sw_i};

    // Decode the settled command. Writes answer with what the register holds
    // afterwards, so an LED write returns only the implemented bits.
    always_comb begin
        rd_val   = 16'h0000;
        mapped   = 1'b0;
        writable = 1'b0;
        case (cmd_addr)
            ADDR_ID: begin
                rd_val = ID_VALUE;
                mapped = 1'b1;
            end
            ADDR_SCRATCH: begin
                rd_val   = scratch_q;
                mapped   = 1'b1;
                writable = 1'b1;
            end
            ADDR_LED: begin
                rd_val   = led_rd;
                mapped   = 1'b1;
                writable = 1'b1;
            end
            ADDR_STATUS: begin
                rd_val = status_val;
                mapped = 1'b1;
            end
            ADDR_TXN: begin
                rd_val = txn_q;
                mapped = 1'b1;
            end
            default: begin
                rd_val = 16'h0000;
            end
        endcase
        rsp_err  = !mapped || (cmd_wr && !writable);
        do_write = cmd_wr && writable;
        if (do_write) begin
            rsp_rdata = (cmd_addr == ADDR_LED) ? {{(16 - LED_W){1'b0}}, cmd_wdata[LED_W-1:0]}
                                               : cmd_wdata;
        end else begin
            rsp_rdata = rd_val;
        end
    end

    // INIT waits until the synchroniser holds the post-reset gp_out level before
    // adopting it as last_req, so a request level left over across reset is not
    // mistaken for a new toggle. last_req is updated on detect, so a toggle that
    // arrives while busy is picked up on the next pass through IDLE.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state     <= INIT;
            init_cnt  <= 2'd0;
            cnt       <= '0;
            last_req  <= 1'b0;
            gp_in_q   <= 32'h0000_0000;
            scratch_q <= 16'h0000;
            led_q     <= '0;
            txn_q     <= 16'h0000;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == 2'd2) begin
                        last_req <= sync_q[CMD_REQ_BIT];
                        state    <= IDLE;
                    end else begin
                        init_cnt <= init_cnt + 2'd1;
                    end
                end
                IDLE: begin
                    if (sync_q[CMD_REQ_BIT] != last_req) begin
                        last_req <= sync_q[CMD_REQ_BIT];
                        cnt      <= '0;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    gp_in_q <= pack_rsp(~gp_in_q[RSP_ACK_BIT], rsp_err, cmd_addr, rsp_rdata);
                    if (do_write && cmd_addr == ADDR_SCRATCH) begin
                        scratch_q <= cmd_wdata;
                    end
                    if (do_write && cmd_addr == ADDR_LED) begin
                        led_q <= cmd_wdata[LED_W-1:0];
                    end
                    txn_q <= txn_q + 16'd1;
                    state <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign gp.gp_in = gp_in_q;
    assign led_o    = led_q;

endmodule
